// File: rtl/leddc_scan_scheduler_if.sv
// Handshake/status bundle between the LED driver scan scheduler and its surroundings.
//   frame_rdy, mode           : loader/control -> scheduler
//   vsync, load_en, scan_line,
//   pass, buf_sel, frame_done,
//   busy, ovf                 : scheduler -> PWM datapath / loader / status
// Modports: slave = scheduler side, master = driving side.
interface leddc_scan_scheduler_if #(
  parameter int unsigned SCANLINES = 32
);
  localparam int unsigned SLW = $clog2(SCANLINES);

  logic           frame_rdy;
  logic           mode;
  logic           vsync;
  logic           load_en;
  logic [SLW-1:0] scan_line;
  logic           pass;
  logic           buf_sel;
  logic           frame_done;
  logic           busy;
  logic           ovf;

  modport slave (
    input  frame_rdy, mode,
    output vsync, load_en, scan_line, pass, buf_sel, frame_done, busy, ovf
  );

  modport master (
    output frame_rdy, mode,
    input  vsync, load_en, scan_line, pass, buf_sel, frame_done, busy, ovf
  );
endinterface

// File: rtl/leddc_scan_scheduler.sv
// GCK-domain scan sequencer for the LED driver PWM datapath. Walks every scanline of a
// frame through LOAD (1 cycle counter-load strobe), PWM (vsync high) and BLANK (vsync low),
// in one pass (mode 0) or two half-depth passes (mode 1), and owns the ping-pong
// frame-buffer select, swapping only at frame boundaries.
// Ports:
//   clk  : GCK, all logic on posedge
//   rst  : asynchronous, active-high reset
//   bus  : leddc_scan_scheduler_if.slave (frame_rdy/mode in; vsync, load_en, scan_line,
//          pass, buf_sel, frame_done, busy, ovf out; all outputs registered)
// Build option: LEDDC_FRAME_REPEAT_EN -- when defined, a frame with no successor pending is
// redisplayed instead of returning to idle.
module leddc_scan_scheduler #(
  parameter int unsigned SCANLINES = 32,
  parameter int unsigned PWM_BITS  = 16,
  parameter int unsigned BLANK_CYC = 4
) (
  input logic                 clk,
  input logic                 rst,
  leddc_scan_scheduler_if.slave bus
);

  localparam int unsigned SLW = $clog2(SCANLINES);
  localparam int unsigned BW  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [SLW-1:0]      LineLast  = SLW'(SCANLINES - 1);
  localparam logic [BW-1:0]       BlankLast = BW'(BLANK_CYC - 1);
  localparam logic [PWM_BITS-1:0] PwmLast0  = '1;
  localparam logic [PWM_BITS-1:0] PwmLast1  = {1'b0, {(PWM_BITS - 1) {1'b1}}};

  typedef enum logic [1:0] {StIdle, StLoad, StPwm, StBlank} state_e;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BW-1:0]       blank_cnt_q, blank_cnt_d;
  logic [SLW-1:0]      line_q, line_d;
  logic                pass_q, pass_d;
  logic                buf_q, buf_d;
  logic                mode_q, mode_d;
  logic                pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                vsync_q, load_en_q, busy_q;
  logic                take;
  logic [PWM_BITS-1:0] pwm_last;

  assign pwm_last = mode_q ? PwmLast1 : PwmLast0;

  always_comb begin
    state_d     = state_q;
    pwm_cnt_d   = pwm_cnt_q;
    blank_cnt_d = blank_cnt_q;
    line_d      = line_q;
    pass_d      = pass_q;
    buf_d       = buf_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    take        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_q) take = 1'b1;
      end
      StLoad: begin
        state_d   = StPwm;
        pwm_cnt_d = '0;
      end
      StPwm: begin
        if (pwm_cnt_q == pwm_last) begin
          state_d     = StBlank;
          blank_cnt_d = '0;
        end else begin
          pwm_cnt_d = pwm_cnt_q + 1'b1;
        end
      end
      StBlank: begin
        if (blank_cnt_q == BlankLast) begin
          if (line_q != LineLast) begin
            line_d  = line_q + 1'b1;
            state_d = StLoad;
          end else if (mode_q && !pass_q) begin
            pass_d  = 1'b1;
            line_d  = '0;
            state_d = StLoad;
          end else begin
            // Frame ends here; frame_done shows up alongside the next state.
            done_d = 1'b1;
            if (pend_q) begin
              take = 1'b1;
            end else begin
`ifdef LEDDC_FRAME_REPEAT_EN
              mode_d  = bus.mode;
              line_d  = '0;
              pass_d  = 1'b0;
              state_d = StLoad;
`else
              state_d = StIdle;
`endif
            end
          end
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Taking a pending frame: swap buffers and start at line 0, pass 0.
    if (take) begin
      buf_d   = ~buf_q;
      mode_d  = bus.mode;
      line_d  = '0;
      pass_d  = 1'b0;
      pend_d  = 1'b0;
      state_d = StLoad;
    end

    // A new frame_rdy always leaves one frame pending; it only overflows if the
    // slot was occupied and not freed this same cycle.
    if (bus.frame_rdy) begin
      if (pend_q && !take) ovf_d = 1'b1;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pwm_cnt_q   <= '0;
      blank_cnt_q <= '0;
      line_q      <= '0;
      pass_q      <= 1'b0;
      buf_q       <= 1'b0;
      mode_q      <= 1'b0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      vsync_q     <= 1'b0;
      load_en_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      line_q      <= line_d;
      pass_q      <= pass_d;
      buf_q       <= buf_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      // Flags registered from the next state so they track state_q without decode glitches.
      vsync_q     <= (state_d == StPwm);
      load_en_q   <= (state_d == StLoad);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign bus.vsync      = vsync_q;
  assign bus.load_en    = load_en_q;
  assign bus.scan_line  = line_q;
  assign bus.pass       = pass_q;
  assign bus.buf_sel    = buf_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = busy_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_leddc_scan_scheduler.sv
// Self-checking bench for leddc_scan_scheduler (SCANLINES=2, PWM_BITS=4, BLANK_CYC=2),
// default build (no frame repeat).
module tb_leddc_scan_scheduler;

  localparam int unsigned SCANLINES = 2;
  localparam int unsigned PWM_BITS  = 4;
  localparam int unsigned BLANK_CYC = 2;
  localparam int          TIMEOUT   = 300;

  typedef struct {
    int line;
    int pass;
    int bsel;
    int win;
  } load_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   loads_seen;
  int   run;
  int   cur_win;
  load_t exp_q[$];

  leddc_scan_scheduler_if #(.SCANLINES(SCANLINES)) bus ();

  leddc_scan_scheduler #(
    .SCANLINES(SCANLINES),
    .PWM_BITS (PWM_BITS),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int line, input int pass, input int bsel, input int win);
    load_t e;
    e.line = line;
    e.pass = pass;
    e.bsel = bsel;
    e.win  = win;
    exp_q.push_back(e);
  endtask

  // Scoreboard: each load_en pops the expected (line, pass, buffer, vsync window);
  // each vsync window is measured against the window of the load that opened it.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      if (bus.load_en) begin
        loads_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_load", 1, 0);
        end else begin
          load_t e;
          e = exp_q.pop_front();
          check("load_line", int'(bus.scan_line), e.line);
          check("load_pass", int'(bus.pass), e.pass);
          check("load_buf", int'(bus.buf_sel), e.bsel);
          check("load_no_vsync", int'(bus.vsync), 0);
          cur_win = e.win;
        end
      end
      if (bus.vsync) begin
        run++;
      end else if (run != 0) begin
        check("vsync_window", run, cur_win);
        run = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rdy();
    bus.frame_rdy = 1'b1;
    @(negedge clk);
    bus.frame_rdy = 1'b0;
  endtask

  task automatic wait_load(input string tag, output int at);
    int k;
    k  = 0;
    at = -1;
    while (k < TIMEOUT) begin
      @(negedge clk);
      if (bus.load_en) begin
        at = cyc;
        break;
      end
      k++;
    end
    if (at < 0) check({tag, "_load_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, output int at);
    int k;
    k  = 0;
    at = -1;
    while (k < TIMEOUT) begin
      @(negedge clk);
      if (bus.frame_done) begin
        at = cyc;
        break;
      end
      k++;
    end
    if (at < 0) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vsync"}, int'(bus.vsync), 0);
    check({tag, "_load_en"}, int'(bus.load_en), 0);
    check({tag, "_line"}, int'(bus.scan_line), 0);
    check({tag, "_pass"}, int'(bus.pass), 0);
    check({tag, "_buf"}, int'(bus.buf_sel), 0);
    check({tag, "_done"}, int'(bus.frame_done), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_ovf"}, int'(bus.ovf), 0);
  endtask

  initial begin
    int t0, t1, t2, base;
    n_checks      = 0;
    n_fail        = 0;
    loads_seen    = 0;
    run           = 0;
    cur_win       = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus.frame_rdy = 1'b0;
    bus.mode      = 1'b0;

    // Reset state, then idle with no frame offered.
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_busy", int'(bus.busy), 0);
      check("idle_vsync", int'(bus.vsync), 0);
    end
    check("idle_buf", int'(bus.buf_sel), 0);
    check("idle_loads", loads_seen, 0);

    // Mode 0 frame: two lines of 16 PWM + 2 blank, 38 cycles load-to-done.
    push(0, 0, 1, 16);
    push(1, 0, 1, 16);
    pulse_rdy();
    wait_load("m0", t0);
    check("m0_buf", int'(bus.buf_sel), 1);
    wait_done("m0", t1);
    check("m0_len", t1 - t0, 38);
    check("m0_busy_at_done", int'(bus.busy), 0);
    tick(5);
    check("m0_idle_busy", int'(bus.busy), 0);

    // Mode 1 frame: (0,0),(1,0),(0,1),(1,1), 8-cycle windows, 44 cycles.
    bus.mode = 1'b1;
    push(0, 0, 0, 8);
    push(1, 0, 0, 8);
    push(0, 1, 0, 8);
    push(1, 1, 0, 8);
    pulse_rdy();
    wait_load("m1", t0);
    check("m1_buf", int'(bus.buf_sel), 0);
    wait_done("m1", t1);
    check("m1_len", t1 - t0, 44);
    tick(3);
    bus.mode = 1'b0;

    // Back-to-back frames with a pending frame and an overflowing third frame_rdy.
    push(0, 0, 1, 16);
    push(1, 0, 1, 16);
    pulse_rdy();
    wait_load("bb", t0);
    tick(6);
    push(0, 0, 0, 16);
    push(1, 0, 0, 16);
    pulse_rdy();
    check("bb_ovf_before", int'(bus.ovf), 0);
    tick(4);
    pulse_rdy();
    check("bb_ovf_set", int'(bus.ovf), 1);
    wait_done("bb_a", t1);
    check("bb_a_len", t1 - t0, 38);
    check("bb_no_idle_load", int'(bus.load_en), 1);
    check("bb_busy", int'(bus.busy), 1);
    check("bb_buf_toggle", int'(bus.buf_sel), 0);
    wait_done("bb_b", t2);
    check("bb_b_len", t2 - t1, 38);
    check("bb_b_busy_at_done", int'(bus.busy), 0);
    check("bb_ovf_sticky", int'(bus.ovf), 1);
    tick(3);

    // Mode flipped during line 0 PWM: current frame keeps mode 0 timing, next uses mode 1.
    push(0, 0, 1, 16);
    push(1, 0, 1, 16);
    pulse_rdy();
    wait_load("mt", t0);
    tick(4);
    check("mt_vsync", int'(bus.vsync), 1);
    bus.mode = 1'b1;
    push(0, 0, 0, 8);
    push(1, 0, 0, 8);
    push(0, 1, 0, 8);
    push(1, 1, 0, 8);
    pulse_rdy();
    wait_done("mt_a", t1);
    check("mt_a_len", t1 - t0, 38);
    wait_done("mt_b", t2);
    check("mt_b_len", t2 - t1, 44);
    bus.mode = 1'b0;
    tick(3);

    // Reset during PWM: outputs drop without waiting for a clock edge.
    push(0, 0, 1, 16);
    pulse_rdy();
    wait_load("rs", t0);
    tick(5);
    check("rs_vsync_before", int'(bus.vsync), 1);
    rst = 1'b1;
    #1;
    check_all_zero("rs_async");
    tick(2);
    rst = 1'b0;
    base = loads_seen;
    tick(20);
    check("rs_idle_busy", int'(bus.busy), 0);
    check("rs_no_pending", loads_seen - base, 0);
    check("rs_buf", int'(bus.buf_sel), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
